// File: rtl/terrain_probe_scheduler.sv
// Shares one fixed-latency terrain BRAM between a five-point ball probe and a
// low-priority render lookup port; probe results publish atomically.
module terrain_probe_scheduler #(
  parameter int unsigned WIDTH        = 160,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned ADDR_W       = 16,
  parameter logic [15:0] PROBE_OFFSET = 16'h0080
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              probe_req,
  input  logic [15:0]       ball_x,
  input  logic [15:0]       ball_y,
  output logic              probe_busy,
  output logic              probe_valid,
  output logic              probe_dropped,
  output logic [1:0]        terrain_center,
  output logic [1:0]        terrain_xplus,
  output logic [1:0]        terrain_xminus,
  output logic [1:0]        terrain_yplus,
  output logic [1:0]        terrain_yminus,
  input  logic              render_req,
  input  logic [ADDR_W-1:0] render_addr,
  output logic              render_grant,
  output logic              render_data_valid,
  output logic [1:0]        render_data,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [1:0]        bram_data
);

  localparam int unsigned NUM_SLOTS = 5;
  localparam int unsigned SLOT_W    = 3;
  localparam int unsigned CNT_W     = $clog2(READ_LATENCY + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state, state_next;
  logic [SLOT_W-1:0] slot, slot_next;
  logic [CNT_W-1:0]  drain_cnt, drain_cnt_next;
  logic              issue, publish, accept;

  logic [15:0]       x_q, y_q;
  logic [ADDR_W-1:0] slot_addr [NUM_SLOTS];

  // Tag pipeline: stage READ_LATENCY-1 describes the data on bram_data now
  logic [READ_LATENCY-1:0] tag_probe;
  logic [READ_LATENCY-1:0] tag_render;
  logic [SLOT_W-1:0]       tag_slot [READ_LATENCY];

  logic [1:0] shadow  [NUM_SLOTS];
  logic [1:0] terrain [NUM_SLOTS];

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [15:0] px,
                                                  input logic [15:0] py);
    logic [15:0] lin;
    lin = (px >> 8) + 16'(WIDTH) * (py >> 8);
    return ADDR_W'(lin);
  endfunction

  // Five probe addresses from the latched ball position (16-bit wrap)
  always_comb begin
    slot_addr[0] = cell_addr(x_q, y_q);
    slot_addr[1] = cell_addr(x_q + PROBE_OFFSET, y_q);
    slot_addr[2] = cell_addr(x_q - PROBE_OFFSET, y_q);
    slot_addr[3] = cell_addr(x_q, y_q + PROBE_OFFSET);
    slot_addr[4] = cell_addr(x_q, y_q - PROBE_OFFSET);
  end

  assign accept = probe_req && (state == IDLE);

  // Next state, BRAM address mux and render grant
  always_comb begin
    state_next     = state;
    slot_next      = slot;
    drain_cnt_next = drain_cnt;
    render_grant   = 1'b0;
    bram_addr      = '0;
    issue          = 1'b0;
    publish        = 1'b0;
    unique case (state)
      IDLE: begin
        render_grant = render_req;
        if (render_req) bram_addr = render_addr;
        if (probe_req) begin
          state_next = ISSUE;
          slot_next  = '0;
        end
      end
      ISSUE: begin
        issue     = 1'b1;
        bram_addr = slot_addr[slot];
        if (slot == SLOT_W'(NUM_SLOTS - 1)) begin
          state_next     = DRAIN;
          drain_cnt_next = '0;
        end else begin
          slot_next = slot + SLOT_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == CNT_W'(READ_LATENCY - 1)) publish = 1'b1;
        if (drain_cnt == CNT_W'(READ_LATENCY)) state_next = IDLE;
        else drain_cnt_next = drain_cnt + CNT_W'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      slot          <= '0;
      drain_cnt     <= '0;
      x_q           <= '0;
      y_q           <= '0;
      tag_probe     <= '0;
      tag_render    <= '0;
      probe_busy    <= 1'b0;
      probe_valid   <= 1'b0;
      probe_dropped <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) tag_slot[i] <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow[i]  <= '0;
        terrain[i] <= '0;
      end
    end else begin
      state         <= state_next;
      slot          <= slot_next;
      drain_cnt     <= drain_cnt_next;
      probe_busy    <= (state_next != IDLE);
      probe_valid   <= publish;
      probe_dropped <= probe_req && (state != IDLE);
      if (accept) begin
        x_q <= ball_x;
        y_q <= ball_y;
      end
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        tag_probe[i]  <= tag_probe[i-1];
        tag_render[i] <= tag_render[i-1];
        tag_slot[i]   <= tag_slot[i-1];
      end
      tag_probe[0]  <= issue;
      tag_render[0] <= render_grant;
      tag_slot[0]   <= slot;
      if (tag_probe[READ_LATENCY-1]) shadow[tag_slot[READ_LATENCY-1]] <= bram_data;
      // Last capture lands on the publish edge, so bypass it straight through
      if (publish) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          terrain[i] <= (tag_probe[READ_LATENCY-1] &&
                         tag_slot[READ_LATENCY-1] == SLOT_W'(i)) ? bram_data : shadow[i];
        end
      end
    end
  end

  assign render_data_valid = tag_render[READ_LATENCY-1];
  assign render_data       = bram_data;

  assign terrain_center = terrain[0];
  assign terrain_xplus  = terrain[1];
  assign terrain_xminus = terrain[2];
  assign terrain_yplus  = terrain[3];
  assign terrain_yminus = terrain[4];

endmodule

// File: tb/tb_terrain_probe_scheduler.sv
// Randomized scenarios for terrain_probe_scheduler against a timeline model
// derived from the probe/render rules; each task checks its own feature.
module tb_terrain_probe_scheduler;

  localparam int MAXC = 40;
  localparam int EXT  = MAXC + 10;

  logic        clk = 1'b0;
  logic        rst_in, probe_req, render_req;
  logic [15:0] ball_x, ball_y, render_addr, bram_addr;
  logic        probe_busy, probe_valid, probe_dropped;
  logic        render_grant, render_data_valid;
  logic [1:0]  render_data, bram_data;
  logic [1:0]  t_c, t_xp, t_xm, t_yp, t_ym;

  always #5 clk = ~clk;

  terrain_probe_scheduler dut (
    .clk_in(clk), .rst_in(rst_in), .probe_req(probe_req),
    .ball_x(ball_x), .ball_y(ball_y),
    .probe_busy(probe_busy), .probe_valid(probe_valid), .probe_dropped(probe_dropped),
    .terrain_center(t_c), .terrain_xplus(t_xp), .terrain_xminus(t_xm),
    .terrain_yplus(t_yp), .terrain_yminus(t_ym),
    .render_req(render_req), .render_addr(render_addr), .render_grant(render_grant),
    .render_data_valid(render_data_valid), .render_data(render_data),
    .bram_addr(bram_addr), .bram_data(bram_data)
  );

  // BRAM with two-cycle read latency
  logic [1:0] mem [65536];
  logic [1:0] d1, d2;
  always @(posedge clk) begin
    d1 <= mem[bram_addr];
    d2 <= d1;
  end
  assign bram_data = d2;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic        st_rst [MAXC], st_req [MAXC], st_rreq [MAXC];
  logic [15:0] st_x [MAXC], st_y [MAXC], st_raddr [MAXC];

  logic [15:0] ob_addr [MAXC];
  logic        ob_grant [MAXC], ob_busy [MAXC], ob_valid [MAXC], ob_drop [MAXC], ob_rdv [MAXC];
  logic [1:0]  ob_rdata [MAXC];
  logic [1:0]  ob_terr [MAXC][5];

  logic        e_aval [EXT], e_grant [EXT], e_busy [EXT], e_valid [EXT], e_drop [EXT], e_rdv [EXT];
  logic [15:0] e_addr [EXT];
  logic [1:0]  e_rdata [EXT];
  logic [1:0]  e_terr [EXT][5];
  logic [1:0]  model_terr [5];

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      st_rst[c] = 0; st_req[c] = 0; st_rreq[c] = 0;
      st_x[c] = 0; st_y[c] = 0; st_raddr[c] = 0;
    end
  endtask

  task automatic add_req(input int c, input logic [15:0] x, input logic [15:0] y);
    st_req[c] = 1; st_x[c] = x; st_y[c] = y;
  endtask

  // Reference: probe accepted when idle, addresses at T+1..T+5, publish at T+8
  task automatic build(input int n);
    int busy_end, pend, ax, ay;
    int a [5];
    logic [1:0] pend_terr [5];
    bit zero_next;
    busy_end = -1; pend = -1; zero_next = 0;
    for (int c = 0; c < EXT; c++) begin
      e_aval[c] = 0; e_grant[c] = 0; e_busy[c] = 0; e_valid[c] = 0;
      e_drop[c] = 0; e_rdv[c] = 0; e_addr[c] = 0; e_rdata[c] = 0;
    end
    for (int c = 0; c < n; c++) begin
      if (zero_next) for (int i = 0; i < 5; i++) model_terr[i] = 0;
      zero_next = 0;
      if (c == pend) for (int i = 0; i < 5; i++) model_terr[i] = pend_terr[i];
      e_valid[c] = (c == pend);
      e_busy[c]  = (c <= busy_end);
      e_grant[c] = st_rreq[c] && !e_busy[c];
      if (e_grant[c]) begin e_aval[c] = 1; e_addr[c] = st_raddr[c]; end
      e_rdv[c] = (c >= 2) && e_grant[c-2] && !st_rst[c-2] && !st_rst[c-1];
      if (e_rdv[c]) e_rdata[c] = mem[e_addr[c-2]];
      for (int i = 0; i < 5; i++) e_terr[c][i] = model_terr[i];
      if (st_rst[c]) begin
        busy_end = c; pend = -1; zero_next = 1;
      end else if (st_req[c]) begin
        if (e_busy[c]) e_drop[c+1] = 1;
        else begin
          ax = int'(st_x[c]); ay = int'(st_y[c]);
          a[0] = ((ax >> 8) + 160 * (ay >> 8)) % 65536;
          a[1] = ((((ax + 128) % 65536) >> 8) + 160 * (ay >> 8)) % 65536;
          a[2] = ((((ax + 65536 - 128) % 65536) >> 8) + 160 * (ay >> 8)) % 65536;
          a[3] = ((ax >> 8) + 160 * (((ay + 128) % 65536) >> 8)) % 65536;
          a[4] = ((ax >> 8) + 160 * (((ay + 65536 - 128) % 65536) >> 8)) % 65536;
          for (int i = 0; i < 5; i++) begin
            e_aval[c+1+i] = 1;
            e_addr[c+1+i] = 16'(a[i]);
            pend_terr[i]  = mem[a[i]];
          end
          busy_end = c + 8; pend = c + 8;
        end
      end
    end
  endtask

  // Drives the stimulus table and records outputs at the falling edge
  task automatic run(input int n);
    build(n);
    for (int c = 0; c < n; c++) begin
      rst_in = st_rst[c]; probe_req = st_req[c]; ball_x = st_x[c]; ball_y = st_y[c];
      render_req = st_rreq[c]; render_addr = st_raddr[c];
      @(negedge clk);
      ob_addr[c] = bram_addr; ob_grant[c] = render_grant; ob_busy[c] = probe_busy;
      ob_valid[c] = probe_valid; ob_drop[c] = probe_dropped; ob_rdv[c] = render_data_valid;
      ob_rdata[c] = render_data;
      ob_terr[c][0] = t_c; ob_terr[c][1] = t_xp; ob_terr[c][2] = t_xm;
      ob_terr[c][3] = t_yp; ob_terr[c][4] = t_ym;
      @(posedge clk); #1;
    end
    rst_in = 0; probe_req = 0; render_req = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1; probe_req = 0; render_req = 0; ball_x = 0; ball_y = 0; render_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({probe_busy, probe_valid, probe_dropped, render_grant, render_data_valid} !== 5'b0)
        $display("FAIL reset_flags cyc%0d got %b want 00000", k,
                 {probe_busy, probe_valid, probe_dropped, render_grant, render_data_valid});
      else pass_cnt++;
      total_cnt++;
      if ({t_c, t_xp, t_xm, t_yp, t_ym} !== 10'b0)
        $display("FAIL reset_terrain cyc%0d got %h want 0", k, {t_c, t_xp, t_xm, t_yp, t_ym});
      else pass_cnt++;
      @(posedge clk); #1;
      rst_in = 0;
    end
    for (int i = 0; i < 5; i++) model_terr[i] = 0;
  endtask

  task automatic test_single();
    int lit [5];
    logic [1:0] tlit [5];
    lit = '{1610, 1611, 1610, 1610, 1450};
    tlit = '{2'd2, 2'd3, 2'd2, 2'd2, 2'd2};
    for (int i = 0; i < 65536; i++) mem[i] = 2'(i % 4);
    clear_stim();
    add_req(1, 16'h0AC0, 16'h0A00);
    run(12);
    for (int c = 0; c < 12; c++) begin
      total_cnt++;
      if (ob_valid[c] !== e_valid[c]) $display("FAIL single_valid cyc%0d got %b want %b", c, ob_valid[c], e_valid[c]);
      else pass_cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (ob_addr[2+i] !== 16'(lit[i])) $display("FAIL single_addr slot%0d got %0d want %0d", i, ob_addr[2+i], lit[i]);
      else pass_cnt++;
      total_cnt++;
      if (ob_terr[9][i] !== tlit[i]) $display("FAIL single_terrain slot%0d got %0d want %0d", i, ob_terr[9][i], tlit[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap_and_random();
    for (int i = 0; i < 65536; i++) mem[i] = 2'($urandom);
    for (int r = 0; r < 6; r++) begin
      clear_stim();
      if (r == 0) add_req(1, 16'h0040, 16'h0000);
      else add_req(1, 16'($urandom), 16'($urandom));
      run(12);
      if (r == 0) begin
        total_cnt++;
        if (ob_addr[4] !== 16'd255) $display("FAIL wrap_xminus got %0d want 255", ob_addr[4]);
        else pass_cnt++;
        total_cnt++;
        if (ob_addr[6] !== 16'd40800) $display("FAIL wrap_yminus got %0d want 40800", ob_addr[6]);
        else pass_cnt++;
      end
      for (int c = 0; c < 12; c++) begin
        if (e_aval[c]) begin
          total_cnt++;
          if (ob_addr[c] !== e_addr[c]) $display("FAIL probe_addr r%0d cyc%0d got %0d want %0d", r, c, ob_addr[c], e_addr[c]);
          else pass_cnt++;
        end
        for (int i = 0; i < 5; i++) begin
          total_cnt++;
          if (ob_terr[c][i] !== e_terr[c][i]) $display("FAIL probe_terrain r%0d cyc%0d slot%0d got %0d want %0d", r, c, i, ob_terr[c][i], e_terr[c][i]);
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_render();
    clear_stim();
    for (int c = 0; c < 18; c++) begin st_rreq[c] = 1; st_raddr[c] = 16'($urandom); end
    add_req(3, 16'($urandom), 16'($urandom));
    run(18);
    for (int c = 0; c < 18; c++) begin
      total_cnt++;
      if (ob_grant[c] !== e_grant[c]) $display("FAIL render_grant cyc%0d got %b want %b", c, ob_grant[c], e_grant[c]);
      else pass_cnt++;
      total_cnt++;
      if (e_aval[c] && ob_addr[c] !== e_addr[c]) $display("FAIL render_addr cyc%0d got %0d want %0d", c, ob_addr[c], e_addr[c]);
      else pass_cnt++;
      total_cnt++;
      if (ob_rdv[c] !== e_rdv[c]) $display("FAIL render_dv cyc%0d got %b want %b", c, ob_rdv[c], e_rdv[c]);
      else pass_cnt++;
      if (e_rdv[c]) begin
        total_cnt++;
        if (ob_rdata[c] !== e_rdata[c]) $display("FAIL render_data cyc%0d got %0d want %0d", c, ob_rdata[c], e_rdata[c]);
        else pass_cnt++;
      end
      total_cnt++;
      if (ob_valid[c] !== e_valid[c]) $display("FAIL render_probe_valid cyc%0d got %b want %b", c, ob_valid[c], e_valid[c]);
      else pass_cnt++;
    end
  endtask

  task automatic test_dropped();
    clear_stim();
    add_req(1, 16'($urandom), 16'($urandom));
    add_req(4, 16'($urandom), 16'($urandom));
    add_req(9, 16'($urandom), 16'($urandom));
    run(14);
    for (int c = 0; c < 14; c++) begin
      total_cnt++;
      if (ob_drop[c] !== e_drop[c]) $display("FAIL dropped cyc%0d got %b want %b", c, ob_drop[c], e_drop[c]);
      else pass_cnt++;
      total_cnt++;
      if (ob_valid[c] !== e_valid[c]) $display("FAIL dropped_valid cyc%0d got %b want %b", c, ob_valid[c], e_valid[c]);
      else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
        total_cnt++;
        if (ob_terr[c][i] !== e_terr[c][i]) $display("FAIL dropped_terrain cyc%0d slot%0d got %0d want %0d", c, i, ob_terr[c][i], e_terr[c][i]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_stim();
    add_req(1, 16'($urandom), 16'($urandom));
    st_rst[6] = 1;
    add_req(9, 16'($urandom), 16'($urandom));
    run(20);
    for (int c = 0; c < 20; c++) begin
      total_cnt++;
      if (ob_valid[c] !== e_valid[c]) $display("FAIL rstmid_valid cyc%0d got %b want %b", c, ob_valid[c], e_valid[c]);
      else pass_cnt++;
      total_cnt++;
      if (ob_busy[c] !== e_busy[c]) $display("FAIL rstmid_busy cyc%0d got %b want %b", c, ob_busy[c], e_busy[c]);
      else pass_cnt++;
      if (e_aval[c]) begin
        total_cnt++;
        if (ob_addr[c] !== e_addr[c]) $display("FAIL rstmid_addr cyc%0d got %0d want %0d", c, ob_addr[c], e_addr[c]);
        else pass_cnt++;
      end
      for (int i = 0; i < 5; i++) begin
        total_cnt++;
        if (ob_terr[c][i] !== e_terr[c][i]) $display("FAIL rstmid_terrain cyc%0d slot%0d got %0d want %0d", c, i, ob_terr[c][i], e_terr[c][i]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    add_req(1, 16'($urandom), 16'($urandom));
    add_req(10, 16'($urandom), 16'($urandom));
    run(22);
    for (int c = 0; c < 22; c++) begin
      total_cnt++;
      if (ob_valid[c] !== e_valid[c]) $display("FAIL b2b_valid cyc%0d got %b want %b", c, ob_valid[c], e_valid[c]);
      else pass_cnt++;
      total_cnt++;
      if (ob_busy[c] !== e_busy[c]) $display("FAIL b2b_busy cyc%0d got %b want %b", c, ob_busy[c], e_busy[c]);
      else pass_cnt++;
      if (e_aval[c]) begin
        total_cnt++;
        if (ob_addr[c] !== e_addr[c]) $display("FAIL b2b_addr cyc%0d got %0d want %0d", c, ob_addr[c], e_addr[c]);
        else pass_cnt++;
      end
      for (int i = 0; i < 5; i++) begin
        total_cnt++;
        if (ob_terr[c][i] !== e_terr[c][i]) $display("FAIL b2b_terrain cyc%0d slot%0d got %0d want %0d", c, i, ob_terr[c][i], e_terr[c][i]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap_and_random();
    test_render();
    test_dropped();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
